vx_barrier_ctl: RTL and testbench
=================================

# vx_barrier_ctl

Per-core warp barrier controller. Warps arriving at a barrier instruction are held until the programmed number of warps has arrived, then released together. The block sits beside the warp scheduler: it takes barrier requests from the warp-control path and drives a stall mask into scheduling readiness. It replaces inline barrier bookkeeping with a handshaked release path and warp-kill cleanup.

## Interface
- NUM_WARPS, 4: warps per core; power of two, ≥2; NW_BITS = log2(NUM_WARPS)
- NUM_BARRIERS, 4: barrier IDs; power of two; NB_BITS = log2(NUM_BARRIERS)
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  barrier arrival request
- req_ready  out  1  request accepted when valid&&ready
- req_wid  in  NW_BITS  arriving warp
- req_bar_id  in  NB_BITS  barrier ID
- req_size_m1  in  NW_BITS  expected warp count minus one
- kill_valid  in  1  warp deactivated (tmc mask zero)
- kill_wid  in  NW_BITS  killed warp
- stall_mask  out  NUM_WARPS  warps blocked on any barrier, pending release included
- rel_valid  out  1  release pending
- rel_ready  in  1  scheduler accepts release
- rel_mask  out  NUM_WARPS  warps being released
- rel_bar_id  out  NB_BITS  released barrier
- err_dup  out  1  one-cycle pulse: duplicate arrival or size mismatch
- busy  out  1  any barrier mask non-zero or release pending

## Operation
- Per barrier b: mask[b] (NUM_WARPS), cnt[b] (NW_BITS, arrivals so far), size[b] (NW_BITS, latched on first arrival).
- FSM: IDLE, REL. req_ready = (state==IDLE).
- IDLE, accepted request (wid w, bar b, size s):
  - mask[b][w] already set → ignore, err_dup=1.
  - cnt[b]!=0 and s!=size[b] → still processed as an arrival using size[b]; err_dup=1.
  - cnt[b]==eff_size (eff_size = s if cnt[b]==0, else size[b]) → rel_mask<=mask[b]|(1<<w), rel_bar_id<=b, clear mask[b], cnt[b]<=0, go REL.
  - else mask[b][w]<=1, cnt[b]<=cnt[b]+1; latch size[b]<=s when cnt[b]==0.
- size_m1==0: immediate release of the single warp.
- REL: hold rel_valid=1 and rel_mask/rel_bar_id stable until rel_ready; on fire go IDLE.
- Kill of warp k, any state: clear mask[b][k] in every barrier that has it set, decrement that cnt[b]; clear rel_mask[k] if in REL. If rel_mask becomes zero due to the kill, rel_valid still completes normally.
- Kill and accepted request for the same warp in the same cycle: kill wins, arrival discarded, no err_dup.
- Kill of a warp in no barrier: no effect.
- stall_mask = OR of all mask[b] | (rel_valid ? rel_mask : 0).
- Counter arithmetic is NW_BITS wide. Wrap-around cannot occur because a release fires at cnt==size_m1 ≤ NUM_WARPS-1.

## Timing
- Reset: all masks/cnt/size 0, state IDLE, rel_valid=0, rel_mask=0, rel_bar_id=0, err_dup=0, stall_mask=0, busy=0, req_ready=1 in the first cycle after reset.
- Arrival accepted at cycle N → stall_mask bit set at N+1.
- Completing arrival at N → rel_valid=1 at N+1, with the arriving warp's stall bit also set at N+1.
- Release fire at M → stall bits for rel_mask clear at M+1; req_ready=1 at M+1.
- Throughput: one arrival per cycle in IDLE; no request accepted during REL.
- err_dup asserts at N+1 for one cycle.
- Reset mid-REL drops the release; all warps unstalled at the next cycle.

## Structure
- Shared package: NW_BITS/NB_BITS derivation and the barrier request struct {wid, bar_id, size_m1}, reused by the warp-control interface.
- One sub-module, vx_barrier_slot: per-barrier mask/cnt/size with arrive/kill/clear inputs and a complete output. Instantiate it NUM_BARRIERS times; the top holds the FSM and release register.

## Test plan
- Barrier 1, size_m1=2; warps 0,2,3 arrive in consecutive cycles → stall_mask 0001, 0101, then rel_valid with rel_mask=1101, rel_bar_id=1; rel_ready held 0 for 3 cycles → stall_mask stays 1101 and req_ready=0; after the fire, stall_mask=0000.
- size_m1=0 from warp 2 → rel_mask=0100 one cycle after acceptance.
- Warp 1 arrives twice at barrier 0 → second arrival gives err_dup pulse, cnt unchanged; warp 3 arriving with size_m1=1 then releases 1010.
- Warps 0,1 wait on barrier 2 (size_m1=2); kill warp 1 → stall_mask=0001; warps 2,3 arrive → rel_mask=1101.
- Same-cycle request and kill for warp 0 → no arrival recorded, stall_mask=0.
- Reset asserted in REL → rel_valid=0, stall_mask=0, busy=0 next cycle.

Source files
------------

// File: rtl/vx_barrier_pkg.sv
// vx_barrier_pkg: shared barrier widths, request struct and controller state encoding.
// Used by the barrier controller and the warp-control path. Defines no ports.
package vx_barrier_pkg;
    localparam int VX_NUM_WARPS    = 4;
    localparam int VX_NUM_BARRIERS = 4;
    localparam int VX_NW_BITS      = $clog2(VX_NUM_WARPS);
    localparam int VX_NB_BITS      = $clog2(VX_NUM_BARRIERS);
    typedef struct packed {
        logic [VX_NW_BITS-1:0] wid;
        logic [VX_NB_BITS-1:0] bar_id;
        logic [VX_NW_BITS-1:0] size_m1;
    } bar_req_t;
    typedef enum logic {BAR_IDLE, BAR_REL} bar_state_e;
endpackage

// File: rtl/vx_barrier_slot.sv
// vx_barrier_slot: one barrier's arrival mask, arrival count and latched size.
// Ports: arrive_i/wid_i/size_m1_i present an arrival, kill_i/kill_wid_i remove a
// warp, mask_o shows waiting warps, complete_o flags the arrival that completes
// the barrier (the slot self-clears), err_o flags a duplicate or size mismatch.
module vx_barrier_slot #(
    parameter int NUM_WARPS = 4,
    parameter int NW_BITS   = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arrive_i,
    input  logic [NW_BITS-1:0]   wid_i,
    input  logic [NW_BITS-1:0]   size_m1_i,
    input  logic                 kill_i,
    input  logic [NW_BITS-1:0]   kill_wid_i,
    output logic [NUM_WARPS-1:0] mask_o,
    output logic                 complete_o,
    output logic                 err_o
);
    logic [NUM_WARPS-1:0] mask_q, mask_d;
    logic [NW_BITS-1:0]   cnt_q, cnt_d, size_q, size_d;
    logic                 dup, first, take, killed;

    assign dup        = mask_q[wid_i];
    assign first      = cnt_q == '0;
    assign take       = arrive_i && !dup;
    // The first arrival defines the barrier size; later ones are held to it.
    assign complete_o = take && cnt_q == (first ? size_m1_i : size_q);
    assign err_o      = arrive_i && (dup || (!first && size_m1_i != size_q));
    assign killed     = kill_i && mask_q[kill_wid_i];
    assign mask_o     = mask_q;

    always_comb begin
        mask_d = mask_q;
        cnt_d  = cnt_q;
        size_d = (take && first) ? size_m1_i : size_q;
        if (complete_o) begin
            mask_d = '0;
            cnt_d  = '0;
        end else if (take) begin
            mask_d[wid_i] = 1'b1;
            cnt_d         = cnt_q + NW_BITS'(1);
        end
        // A killed waiter leaves the count; on completion the slot is already empty.
        if (killed) begin
            mask_d[kill_wid_i] = 1'b0;
            cnt_d              = complete_o ? '0 : cnt_d - NW_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= '0;
            cnt_q  <= '0;
            size_q <= '0;
        end else begin
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
            size_q <= size_d;
        end
    end
endmodule

// File: rtl/vx_barrier_ctl.sv
// vx_barrier_ctl: per-core warp barrier controller with handshaked release.
// Ports: req_* barrier arrivals (accepted when req_ready), kill_* warp removal,
// stall_mask warps held (pending release included), rel_* release handshake,
// err_dup one-cycle duplicate/size-mismatch pulse, busy any barrier activity.
module vx_barrier_ctl
    import vx_barrier_pkg::*;
#(
    parameter int NUM_WARPS    = VX_NUM_WARPS,
    parameter int NUM_BARRIERS = VX_NUM_BARRIERS,
    parameter int NW_BITS      = $clog2(NUM_WARPS),
    parameter int NB_BITS      = $clog2(NUM_BARRIERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW_BITS-1:0]   req_wid,
    input  logic [NB_BITS-1:0]   req_bar_id,
    input  logic [NW_BITS-1:0]   req_size_m1,
    input  logic                 kill_valid,
    input  logic [NW_BITS-1:0]   kill_wid,
    output logic [NUM_WARPS-1:0] stall_mask,
    output logic                 rel_valid,
    input  logic                 rel_ready,
    output logic [NUM_WARPS-1:0] rel_mask,
    output logic [NB_BITS-1:0]   rel_bar_id,
    output logic                 err_dup,
    output logic                 busy
);
    bar_state_e                             state_q, state_d;
    logic [NUM_WARPS-1:0]                   rel_mask_q, rel_mask_d;
    logic [NB_BITS-1:0]                     rel_bar_q, rel_bar_d;
    logic                                   err_q;
    logic [NUM_BARRIERS-1:0][NUM_WARPS-1:0] masks;
    logic [NUM_BARRIERS-1:0]                done, errs;
    logic [NUM_WARPS-1:0]                   held, kill_clr, arr_bit;
    logic                                   arr;

    // A kill of the arriving warp in the same cycle discards the arrival.
    assign arr      = req_valid && req_ready && !(kill_valid && kill_wid == req_wid);
    assign arr_bit  = NUM_WARPS'(1) << req_wid;
    assign kill_clr = kill_valid ? ~(NUM_WARPS'(1) << kill_wid) : '1;

    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_slot
        vx_barrier_slot #(.NUM_WARPS(NUM_WARPS), .NW_BITS(NW_BITS)) u_slot (
            .clk       (clk),
            .reset     (reset),
            .arrive_i  (arr && req_bar_id == NB_BITS'(g)),
            .wid_i     (req_wid),
            .size_m1_i (req_size_m1),
            .kill_i    (kill_valid),
            .kill_wid_i(kill_wid),
            .mask_o    (masks[g]),
            .complete_o(done[g]),
            .err_o     (errs[g])
        );
    end

    always_comb begin
        held = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) held |= masks[b];
    end

    always_comb begin
        state_d    = state_q;
        rel_mask_d = rel_mask_q & kill_clr;
        rel_bar_d  = rel_bar_q;
        if (state_q == BAR_IDLE && |done) begin
            state_d    = BAR_REL;
            rel_mask_d = (masks[req_bar_id] | arr_bit) & kill_clr;
            rel_bar_d  = req_bar_id;
        end else if (state_q == BAR_REL && rel_ready) begin
            state_d    = BAR_IDLE;
            rel_mask_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BAR_IDLE;
            rel_mask_q <= '0;
            rel_bar_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rel_mask_q <= rel_mask_d;
            rel_bar_q  <= rel_bar_d;
            err_q      <= |errs;
        end
    end

    assign req_ready  = state_q == BAR_IDLE;
    assign rel_valid  = state_q == BAR_REL;
    assign rel_mask   = rel_mask_q;
    assign rel_bar_id = rel_bar_q;
    assign err_dup    = err_q;
    assign stall_mask = held | (rel_valid ? rel_mask_q : '0);
    assign busy       = |held || rel_valid;
endmodule

// File: tb/tb_vx_barrier_ctl.sv
// tb_vx_barrier_ctl: scenario-driven bench with a release scoreboard for vx_barrier_ctl.
module tb_vx_barrier_ctl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_wid = '0;
    logic [1:0] req_bar_id = '0;
    logic [1:0] req_size_m1 = '0;
    logic       kill_valid = 1'b0;
    logic [1:0] kill_wid = '0;
    logic [3:0] stall_mask;
    logic       rel_valid;
    logic       rel_ready = 1'b0;
    logic [3:0] rel_mask;
    logic [1:0] rel_bar_id;
    logic       err_dup;
    logic       busy;

    typedef struct {
        logic [3:0] mask;
        logic [1:0] bar;
    } rel_t;
    rel_t sb[$];
    int   total = 0;
    int   bad = 0;

    vx_barrier_ctl #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wid    (req_wid),
        .req_bar_id (req_bar_id),
        .req_size_m1(req_size_m1),
        .kill_valid (kill_valid),
        .kill_wid   (kill_wid),
        .stall_mask (stall_mask),
        .rel_valid  (rel_valid),
        .rel_ready  (rel_ready),
        .rel_mask   (rel_mask),
        .rel_bar_id (rel_bar_id),
        .err_dup    (err_dup),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arrive(input int w, input int b, input int s);
        req_valid   = 1'b1;
        req_wid     = 2'(w);
        req_bar_id  = 2'(b);
        req_size_m1 = 2'(s);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic kill(input int w);
        kill_valid = 1'b1;
        kill_wid   = 2'(w);
        tick();
        kill_valid = 1'b0;
    endtask

    task automatic push_rel(input logic [3:0] m, input logic [1:0] b);
        rel_t e;
        e.mask = m;
        e.bar  = b;
        sb.push_back(e);
    endtask

    task automatic do_release(input string name);
        int   n = 0;
        rel_t e;
        while (!rel_valid && n < 8) begin
            tick();
            n++;
        end
        total++;
        if (!rel_valid) begin
            bad++;
            $display("FAIL %s: rel_valid got=0 want=1 within 8 cycles", name);
        end else if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: release mask=%b bar=%0d got, no release expected", name, rel_mask, rel_bar_id);
        end else begin
            e = sb.pop_front();
            if (rel_mask !== e.mask || rel_bar_id !== e.bar) begin
                bad++;
                $display("FAIL %s: release got mask=%b bar=%0d want mask=%b bar=%0d", name, rel_mask, rel_bar_id, e.mask, e.bar);
            end
            rel_ready = 1'b1;
            tick();
            rel_ready = 1'b0;
            total++;
            if ({stall_mask, req_ready, rel_valid, busy} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL %s_after: stall=%b ready=%b relv=%b busy=%b want stall=0000 ready=1 relv=0 busy=0", name, stall_mask, req_ready, rel_valid, busy);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        total++;
        if ({stall_mask, rel_valid, rel_mask, rel_bar_id, err_dup, busy, req_ready} !== {4'b0, 1'b0, 4'b0, 2'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset: stall=%b relv=%b relm=%b relb=%0d err=%b busy=%b ready=%b want all zero with ready=1", stall_mask, rel_valid, rel_mask, rel_bar_id, err_dup, busy, req_ready);
        end
    endtask

    task automatic test_basic();
        arrive(0, 1, 2);
        total++;
        if ({stall_mask, rel_valid} !== {4'b0001, 1'b0}) begin
            bad++;
            $display("FAIL basic_w0: stall=%b relv=%b want 0001/0", stall_mask, rel_valid);
        end
        arrive(2, 1, 2);
        total++;
        if ({stall_mask, rel_valid} !== {4'b0101, 1'b0}) begin
            bad++;
            $display("FAIL basic_w2: stall=%b relv=%b want 0101/0", stall_mask, rel_valid);
        end
        push_rel(4'b1101, 2'd1);
        arrive(3, 1, 2);
        total++;
        if ({stall_mask, rel_valid, rel_mask} !== {4'b1101, 1'b1, 4'b1101}) begin
            bad++;
            $display("FAIL basic_w3: stall=%b relv=%b relm=%b want 1101/1/1101", stall_mask, rel_valid, rel_mask);
        end
        for (int i = 0; i < 3; i++) begin
            req_valid   = 1'b1;
            req_wid     = 2'd1;
            req_bar_id  = 2'd0;
            req_size_m1 = 2'd0;
            tick();
            total++;
            if ({stall_mask, req_ready, rel_valid} !== {4'b1101, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL basic_hold%0d: stall=%b ready=%b relv=%b want 1101/0/1", i, stall_mask, req_ready, rel_valid);
            end
        end
        req_valid = 1'b0;
        do_release("basic_rel");
    endtask

    task automatic test_single();
        push_rel(4'b0100, 2'd3);
        arrive(2, 3, 0);
        total++;
        if ({rel_valid, rel_mask, stall_mask, busy} !== {1'b1, 4'b0100, 4'b0100, 1'b1}) begin
            bad++;
            $display("FAIL single: relv=%b relm=%b stall=%b busy=%b want 1/0100/0100/1", rel_valid, rel_mask, stall_mask, busy);
        end
        do_release("single_rel");
    endtask

    task automatic test_dup();
        arrive(1, 0, 1);
        arrive(1, 0, 1);
        total++;
        if ({err_dup, stall_mask, rel_valid} !== {1'b1, 4'b0010, 1'b0}) begin
            bad++;
            $display("FAIL dup: err=%b stall=%b relv=%b want 1/0010/0", err_dup, stall_mask, rel_valid);
        end
        tick();
        total++;
        if (err_dup !== 1'b0) begin
            bad++;
            $display("FAIL dup_pulse: err=%b want 0", err_dup);
        end
        push_rel(4'b1010, 2'd0);
        arrive(3, 0, 1);
        total++;
        if ({err_dup, rel_valid} !== {1'b0, 1'b1}) begin
            bad++;
            $display("FAIL dup_done: err=%b relv=%b want 0/1", err_dup, rel_valid);
        end
        do_release("dup_rel");
        arrive(0, 3, 1);
        push_rel(4'b0101, 2'd3);
        arrive(2, 3, 3);
        total++;
        if ({err_dup, rel_valid} !== {1'b1, 1'b1}) begin
            bad++;
            $display("FAIL mismatch: err=%b relv=%b want 1/1", err_dup, rel_valid);
        end
        do_release("mismatch_rel");
    endtask

    task automatic test_kill();
        arrive(0, 2, 2);
        arrive(1, 2, 2);
        kill(1);
        total++;
        if (stall_mask !== 4'b0001) begin
            bad++;
            $display("FAIL kill_wait: stall=%b want 0001", stall_mask);
        end
        arrive(2, 2, 2);
        push_rel(4'b1101, 2'd2);
        arrive(3, 2, 2);
        total++;
        if ({rel_valid, stall_mask} !== {1'b1, 4'b1101}) begin
            bad++;
            $display("FAIL kill_done: relv=%b stall=%b want 1/1101", rel_valid, stall_mask);
        end
        do_release("kill_rel");
        kill(2);
        total++;
        if ({stall_mask, busy} !== {4'b0000, 1'b0}) begin
            bad++;
            $display("FAIL kill_idle: stall=%b busy=%b want 0000/0", stall_mask, busy);
        end
        arrive(0, 1, 1);
        arrive(1, 1, 1);
        push_rel(4'b0000, 2'd1);
        kill(0);
        total++;
        if ({stall_mask, rel_valid} !== {4'b0010, 1'b1}) begin
            bad++;
            $display("FAIL kill_rel0: stall=%b relv=%b want 0010/1", stall_mask, rel_valid);
        end
        kill(1);
        total++;
        if ({stall_mask, rel_valid, busy} !== {4'b0000, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL kill_rel1: stall=%b relv=%b busy=%b want 0000/1/1", stall_mask, rel_valid, busy);
        end
        do_release("kill_empty_rel");
    endtask

    task automatic test_same_cycle();
        req_valid   = 1'b1;
        req_wid     = 2'd0;
        req_bar_id  = 2'd0;
        req_size_m1 = 2'd1;
        kill_valid  = 1'b1;
        kill_wid    = 2'd0;
        tick();
        req_valid  = 1'b0;
        kill_valid = 1'b0;
        total++;
        if ({stall_mask, err_dup, busy} !== {4'b0000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL same_cycle: stall=%b err=%b busy=%b want 0000/0/0", stall_mask, err_dup, busy);
        end
        arrive(0, 0, 1);
        total++;
        if ({stall_mask, err_dup, rel_valid} !== {4'b0001, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL same_cycle_re: stall=%b err=%b relv=%b want 0001/0/0", stall_mask, err_dup, rel_valid);
        end
        push_rel(4'b0011, 2'd0);
        arrive(1, 0, 1);
        do_release("same_cycle_rel");
    endtask

    task automatic test_reset_rel();
        arrive(3, 1, 0);
        total++;
        if (rel_valid !== 1'b1) begin
            bad++;
            $display("FAIL rst_rel_pre: relv=%b want 1", rel_valid);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if ({rel_valid, stall_mask, busy, req_ready} !== {1'b0, 4'b0000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL rst_rel: relv=%b stall=%b busy=%b ready=%b want 0/0000/0/1", rel_valid, stall_mask, busy, req_ready);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: pending=%0d want 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_dup();
        test_kill();
        test_same_cycle();
        test_reset_rel();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
